floor_request_queue: RTL
========================

# floor_request_queue

Hall-call request manager for the elevator datapath. Sits between the synchronized floor switches and the direction/floor-control logic. Turns button presses into latched pending requests, runs a SCAN (collective) scheduler that produces the travel direction and next target floor, and clears each request with a timed door dwell when the car reaches that floor. It is the responder to the floor-control path: floor control reports where the car is, and this block decides where the car goes next.

## Interface
- FLOORS, 6: number of floors; width of every one-hot floor vector.
- DWELL, 3: cycles the door stays open per stop; must be ≥1.
- DW, $clog2(DWELL+1): dwell counter width (derived, do not override).

- clk  in  1  system clock (the divided elevator tick).
- reset  in  1  asynchronous, active-low; 0 = reset.
- call  in  FLOORS  synchronized floor buttons, level, bit i = floor i.
- current_floor  in  FLOORS  one-hot car position from floor control.
- pending  out  FLOORS  latched outstanding requests.
- target  out  FLOORS  one-hot next stop; 0 when idle.
- direction  out  2  2'b10 up, 2'b01 down, 2'b00 stopped.
- door_open  out  1  high while the car dwells at a floor.

## Operation
- Edge detect: call_q <= call; press = call & ~call_q. A held button counts once.
- Press on floor i that is not the current floor sets pending[i].
- Press on the current floor never sets pending. In IDLE it enters DOOR. In DOOR it reloads the dwell counter.
- Definitions: above = pending bits above the current floor; below = pending bits below it. Floor index comes from the one-hot current_floor.
- States: IDLE, UP, DOWN, DOOR. Last travel direction last_dir is stored and is reset to up.
- IDLE: if above is nonzero, go to UP. Otherwise, if below is nonzero, go to DOWN. Otherwise stay.
- UP: target = lowest set bit of above. If (current_floor & pending) != 0, clear that bit, go to DOOR, set last_dir = up. If above becomes 0 without an arrival (cancel only), go to DOWN if below is nonzero, else IDLE.
- DOWN: mirror of UP. target = highest set bit of below.
- DOOR: counter is loaded with DWELL-1 on entry and counts down. When it is 0, re-evaluate: continue in last_dir if that side is nonzero, else go to the opposite side if nonzero, else IDLE.
- direction and door_open are decoded from state (Moore):
  - UP gives 10, DOWN gives 01, IDLE and DOOR give 00.
  - door_open = (state == DOOR).
- current_floor that is zero or multi-hot: no arrival is detected, state holds, and nothing is cleared.

## Timing
- Reset, asynchronous: pending=0, target=0, direction=00, door_open=0, state=IDLE, call_q=0, counter=0, last_dir=up.
- pending[i] rises at the first clk edge that samples call[i]=1 after it was 0.
- direction and target update one clk edge after the pending change that caused them.
- Arrival: at the edge where current_floor matches a pending bit, that bit clears, door_open rises, direction becomes 00 and target becomes 0. door_open stays high for exactly DWELL cycles.
- A same-floor press during DOOR extends the dwell so it ends DWELL cycles after that press's sampling edge.
- Press on floor i in the same cycle the car arrives at floor i: the arrival wins, pending[i] stays 0, and the dwell is not extended twice.
- Simultaneous presses on several floors all latch in the same cycle.
- Reset asserted mid-move or mid-dwell forces the reset values immediately; no request survives.

## Configuration
- FLOOR_REQ_CANCEL_EN
  - Defined: a press on floor i with pending[i]=1 (and i not the current floor) clears pending[i] at the next edge. A pending floor removed this way is no longer a target; UP/DOWN follow the fallback rule above.
  - Undefined: presses on already-pending floors are ignored.

## Test plan
- Single call. FLOORS=6, DWELL=3, current_floor=000001, pulse call[5].
  - pending=100000 next edge.
  - direction=10 and target=100000 one edge later.
  - Drive current_floor to 100000: door_open high 3 cycles, pending=000000, then direction=00 and IDLE.
- Collective up/down. Car at 000100 moving up to floor 5; press call[4] and call[0] together.
  - Stops at floor 4 (pending 100001 after clear), then at floor 5.
  - After the dwell, direction=01, target=000001.
- Same-floor call. IDLE at 000100, hold call[2] high 10 cycles.
  - door_open for 3 cycles only, pending never set.
  - A re-press on cycle 2 of DOOR extends door_open to 3 cycles past that press.
- Reset mid-operation. In UP with pending=110000, drive reset=0 between clock edges.
  - All outputs 0 immediately, before the next edge.
  - After release, IDLE with no motion.
- Arrival/press collision. Car reaches floor 3 in the same cycle call[3] rises.
  - pending[3]=0, exactly one DWELL of 3 cycles.
- Cancel, built with and without FLOOR_REQ_CANCEL_EN. pending=010000 in UP, press call[4] again.
  - Defined: pending=000000, then IDLE with direction=00.
  - Undefined: pending stays 010000.

Source files
------------

// File: rtl/floor_request_queue.sv
//------------------------------------------------------------------------------
// floor_request_queue
//
// Hall-call request manager. Latches floor-button presses as pending requests,
// runs a SCAN (collective) scheduler that picks the travel direction and the
// next stop, and clears each request with a timed door dwell when the car
// reaches that floor.
//
// Parameters
//   FLOORS  number of floors; width of every one-hot floor vector
//   DWELL   cycles the door stays open per stop (>= 1)
//   DW      dwell counter width, derived from DWELL (leave at default)
//
// Ports
//   clk            in   system clock (divided elevator tick)
//   reset          in   asynchronous, active-low reset
//   call           in   synchronized floor buttons, level, bit i = floor i
//   current_floor  in   one-hot car position reported by floor control
//   pending        out  latched outstanding requests
//   target         out  one-hot next stop, zero when not travelling
//   direction      out  2'b10 up, 2'b01 down, 2'b00 stopped
//   door_open      out  high while the car dwells at a floor
//
// Build option
//   FLOOR_REQ_CANCEL_EN  when defined, pressing an already-pending floor
//                        (other than the current floor) withdraws it.
//------------------------------------------------------------------------------
module floor_request_queue #(
   parameter int FLOORS = 6,
   parameter int DWELL  = 3,
   parameter int DW     = $clog2(DWELL + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] call,
   input  logic [FLOORS-1:0] current_floor,
   output logic [FLOORS-1:0] pending,
   output logic [FLOORS-1:0] target,
   output logic [1:0]        direction,
   output logic              door_open
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_DOOR = 2'b11
   } state_t;

   localparam logic [1:0]        DIR_UP     = 2'b10;
   localparam logic [1:0]        DIR_DOWN   = 2'b01;
   localparam logic [1:0]        DIR_STOP   = 2'b00;
   localparam logic [DW-1:0]     DWELL_LOAD = DW'(DWELL - 1);
   localparam logic [FLOORS-1:0] ONE        = FLOORS'(1);

   // Isolates the lowest set bit (nearest floor above when travelling up).
   function automatic logic [FLOORS-1:0] lowest_bit(input logic [FLOORS-1:0] v);
      return v & (~v + ONE);
   endfunction

   // Isolates the highest set bit (nearest floor below when travelling down).
   function automatic logic [FLOORS-1:0] highest_bit(input logic [FLOORS-1:0] v);
      logic [FLOORS-1:0] r;
      r = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // Registered state
   state_t            state_r;
   logic [FLOORS-1:0] call_q_r;
   logic [DW-1:0]     cnt_r;
   logic              last_dir_r;   // 1 = up, 0 = down

   // Combinational helpers
   logic [FLOORS-1:0] press_s;
   logic              floor_ok_s;
   logic [FLOORS-1:0] below_mask_s;
   logic [FLOORS-1:0] above_mask_s;
   logic [FLOORS-1:0] above_s;
   logic [FLOORS-1:0] below_s;
   logic [FLOORS-1:0] here_s;
   logic              local_press_s;
   logic [FLOORS-1:0] remote_s;
   logic [FLOORS-1:0] set_s;
   logic [FLOORS-1:0] cancel_s;
   logic              arrive_s;
   logic [FLOORS-1:0] clear_s;
   logic              prefer_up_s;
   state_t            resume_s;
   logic [FLOORS-1:0] resume_target_s;
   logic [1:0]        resume_dir_s;

   // Press detection, floor masks, request set/clear and the SCAN choice.
   always_comb begin
      press_s = call & ~call_q_r;

      // Exactly one bit set; zero or multi-hot positions disable arrivals.
      floor_ok_s = (current_floor != '0) &&
                   ((current_floor & (current_floor - ONE)) == '0);

      // For a one-hot position, subtracting one sets every bit below it.
      below_mask_s = current_floor - ONE;
      above_mask_s = ~(below_mask_s | current_floor);

      if (floor_ok_s) begin
         above_s       = pending & above_mask_s;
         below_s       = pending & below_mask_s;
         here_s        = pending & current_floor;
         local_press_s = ((press_s & current_floor) != '0);
      end else begin
         above_s       = '0;
         below_s       = '0;
         here_s        = '0;
         local_press_s = 1'b0;
      end

      // A press on the floor the car occupies is never latched.
      remote_s = press_s & ~current_floor;

`ifdef FLOOR_REQ_CANCEL_EN
      set_s    = remote_s & ~pending;
      cancel_s = remote_s & pending;
`else
      set_s    = remote_s;
      cancel_s = '0;
`endif

      arrive_s = floor_ok_s && ((state_r == ST_UP) || (state_r == ST_DOWN)) &&
                 (here_s != '0);

      if (arrive_s) begin
         clear_s = here_s | cancel_s;
      end else begin
         clear_s = cancel_s;
      end

      // Direction preference: keep going the way we were heading.
      if (state_r == ST_DOOR) begin
         prefer_up_s = last_dir_r;
      end else if (state_r == ST_DOWN) begin
         prefer_up_s = 1'b0;
      end else begin
         prefer_up_s = 1'b1;
      end

      if (prefer_up_s) begin
         if (above_s != '0) begin
            resume_s = ST_UP;
         end else if (below_s != '0) begin
            resume_s = ST_DOWN;
         end else begin
            resume_s = ST_IDLE;
         end
      end else begin
         if (below_s != '0) begin
            resume_s = ST_DOWN;
         end else if (above_s != '0) begin
            resume_s = ST_UP;
         end else begin
            resume_s = ST_IDLE;
         end
      end

      case (resume_s)
         ST_UP: begin
            resume_target_s = lowest_bit(above_s);
            resume_dir_s    = DIR_UP;
         end
         ST_DOWN: begin
            resume_target_s = highest_bit(below_s);
            resume_dir_s    = DIR_DOWN;
         end
         default: begin
            resume_target_s = '0;
            resume_dir_s    = DIR_STOP;
         end
      endcase
   end

   // Button edge-detect history and the pending request register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         call_q_r <= '0;
         pending  <= '0;
      end else begin
         call_q_r <= call;
         pending  <= (pending | set_s) & ~clear_s;
      end
   end

   // Scheduler FSM with its dwell counter and registered Moore outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         last_dir_r <= 1'b1;
         target     <= '0;
         direction  <= DIR_STOP;
         door_open  <= 1'b0;
      end else if (floor_ok_s) begin
         case (state_r)
            ST_IDLE: begin
               if (local_press_s) begin
                  state_r   <= ST_DOOR;
                  cnt_r     <= DWELL_LOAD;
                  target    <= '0;
                  direction <= DIR_STOP;
                  door_open <= 1'b1;
               end else begin
                  state_r   <= resume_s;
                  target    <= resume_target_s;
                  direction <= resume_dir_s;
                  door_open <= 1'b0;
               end
            end
            ST_UP, ST_DOWN: begin
               if (arrive_s) begin
                  state_r    <= ST_DOOR;
                  cnt_r      <= DWELL_LOAD;
                  last_dir_r <= (state_r == ST_UP);
                  target     <= '0;
                  direction  <= DIR_STOP;
                  door_open  <= 1'b1;
               end else begin
                  // Covers both normal travel and fallback after a cancel.
                  state_r   <= resume_s;
                  target    <= resume_target_s;
                  direction <= resume_dir_s;
                  door_open <= 1'b0;
               end
            end
            ST_DOOR: begin
               if (local_press_s) begin
                  // Same-floor press restarts the full dwell.
                  cnt_r <= DWELL_LOAD;
               end else if (cnt_r != '0) begin
                  cnt_r <= cnt_r - DW'(1);
               end else begin
                  state_r   <= resume_s;
                  target    <= resume_target_s;
                  direction <= resume_dir_s;
                  door_open <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               cnt_r     <= '0;
               target    <= '0;
               direction <= DIR_STOP;
               door_open <= 1'b0;
            end
         endcase
      end else begin
         // Invalid position: hold everything until floor control recovers.
         state_r <= state_r;
      end
   end

endmodule
